alu_muldiv: RTL and testbench
=============================

ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 32, operand and result width in bits, legal range 8 to 64.
REQ-002 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-003 Port clk  input  1  rising-edge clock.
REQ-004 Port rst_n  input  1  asynchronous active-low reset.
REQ-005 Port in_valid  input  1  operation request valid.
REQ-006 Port in_ready  output  1  block can accept a request.
REQ-007 Port op1  input  WIDTH  first operand, unsigned.
REQ-008 Port op2  input  WIDTH  second operand, unsigned.
REQ-009 Port ctrl  input  4  operation select.
REQ-010 Port out_valid  output  1  result valid.
REQ-011 Port out_ready  input  1  consumer accepts the result.
REQ-012 Port result  output  WIDTH  operation result.
REQ-013 Port eq  output  1  registered (op1 == op2) of the accepted request.
REQ-014 Port busy  output  1  high while an iterative operation is in progress.

Function
REQ-015 A request SHALL be accepted on a rising clk edge where in_valid=1 and in_ready=1; op1, op2 and ctrl SHALL be captured at that edge and ignored afterwards.
REQ-016 The state machine SHALL have three states: IDLE (in_ready=1), BUSY (iterating), DONE (out_valid=1); in_ready SHALL be 0 outside IDLE.
REQ-017 Single-cycle ops SHALL use these ctrl codes: 0000 add; 0001 sub; 0101 unsigned less-than (result 1 or 0); 0011 or; 0010 and. For these ops: IDLE->DONE, out_valid=1 on the cycle after acceptance.
REQ-018 Iterative ops SHALL use these ctrl codes: 1000 MUL (low WIDTH bits of product); 1001 MULHU (high WIDTH bits); 1100 DIVU (quotient); 1101 REMU (remainder). For these ops: IDLE->BUSY, exactly WIDTH BUSY cycles (one bit per cycle, shift-add multiply, restoring divide), then DONE; out_valid SHALL rise WIDTH+1 cycles after acceptance.
REQ-019 Any other ctrl code SHALL complete as a single-cycle op with result=0.
REQ-020 add/sub SHALL wrap modulo 2^WIDTH; no carry or overflow output.
REQ-021 DIVU with op2=0 SHALL give all-ones; REMU with op2=0 SHALL give op1; both SHALL still take WIDTH+1 cycles.
REQ-022 The iteration counter SHALL be clog2(WIDTH)+1 bits wide, loaded on acceptance and decremented each BUSY cycle; DONE SHALL be entered when it reaches zero.
REQ-023 In DONE, result and eq SHALL hold stable until out_ready=1; on that edge the block SHALL return to IDLE, and out_valid SHALL be 0 the next cycle.
REQ-024 in_ready SHALL be 0 in DONE even when out_ready=1 (no same-cycle accept and retire); back-to-back single-cycle throughput SHALL therefore be one result per 2 cycles.
REQ-025 busy SHALL equal (state==BUSY); in_valid during BUSY or DONE SHALL be ignored.
REQ-026 result SHALL be registered; it SHALL NOT change combinationally with op1, op2 or ctrl.

Reset
REQ-027 rst_n=0 SHALL force IDLE, in_ready=1, out_valid=0, busy=0, result=0, eq=0, and counter=0, immediately and asynchronously.
REQ-028 Reset in BUSY or DONE SHALL abort the operation; no result SHALL be delivered for it.
REQ-029 Reset release SHALL be synchronous to clk; the first accept SHALL be possible on the first rising edge with rst_n=1.

Configuration
REQ-030 The macro ALU_MULDIV_DIV_EN SHALL select the divider. When defined, DIVU/REMU SHALL behave per REQ-018 and REQ-021. When undefined, no divider logic SHALL be present and ctrl 1100/1101 SHALL complete single-cycle per REQ-019 with result=0; MUL/MULHU SHALL be unaffected.

Verification
REQ-031 WIDTH=32: op1=7, op2=5, ctrl=0001 -> out_valid the next cycle, result=2, eq=0; with out_ready=1, IDLE the following cycle.
REQ-032 WIDTH=32: op1=0xFFFFFFFF, op2=2, ctrl=1001 -> busy for 32 cycles, result=1 at cycle 33; ctrl=1000 with the same operands -> result=0xFFFFFFFE.
REQ-033 ALU_MULDIV_DIV_EN defined: op1=100, op2=7, ctrl=1100 -> result=14; ctrl=1101 -> result=2; op2=0 -> DIVU result=0xFFFFFFFF, REMU result=100.
REQ-034 Hold out_ready=0 for 10 cycles in DONE -> out_valid, result and eq stable, in_ready=0, and a new in_valid is ignored.
REQ-035 Assert rst_n=0 at BUSY cycle 10 of a MUL -> all outputs take reset values immediately; after release, add 3+4 -> result=7 with no stale product.
REQ-036 ALU_MULDIV_DIV_EN undefined: ctrl=1100 -> result=0 one cycle after acceptance, busy never asserted.

Source files
------------

// File: rtl/alu_muldiv.sv
// alu_muldiv: handshaked ALU with an iterative shift-add multiplier and optional restoring divider.
// Define ALU_MULDIV_DIV_EN to build the divider (DIVU/REMU); otherwise those codes complete single-cycle with result 0.
module alu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [3:0]       ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             eq,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] work;
    logic [WIDTH-1:0]   operand;
    logic               want_hi;
    logic               is_iter;
    logic [WIDTH-1:0]   alu_res;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] work_next;
`ifdef ALU_MULDIV_DIV_EN
    logic               is_div;
    logic [WIDTH:0]     div_trial;
`endif

    always_comb begin
        alu_res = '0;
        is_iter = 1'b0;
        case (ctrl)
            4'b0000: alu_res = op1 + op2;
            4'b0001: alu_res = op1 - op2;
            4'b0101: alu_res = WIDTH'(op1 < op2);
            4'b0011: alu_res = op1 | op2;
            4'b0010: alu_res = op1 & op2;
            4'b1000, 4'b1001: is_iter = 1'b1;
`ifdef ALU_MULDIV_DIV_EN
            4'b1100, 4'b1101: is_iter = 1'b1;
`endif
            default: alu_res = '0;
        endcase
    end

    // work holds {high accumulator, multiplier} for MUL, {remainder, dividend/quotient} for DIV
    always_comb begin
        mul_sum   = {1'b0, work[2*WIDTH-1:WIDTH]} + (work[0] ? {1'b0, operand} : '0);
        work_next = {mul_sum, work[WIDTH-1:1]};
`ifdef ALU_MULDIV_DIV_EN
        div_trial = {work[2*WIDTH-1:WIDTH], work[WIDTH-1]} - {1'b0, operand};
        if (is_div) begin
            if (!div_trial[WIDTH])
                work_next = {div_trial[WIDTH-1:0], work[WIDTH-2:0], 1'b1};
            else
                work_next = {work[2*WIDTH-2:0], 1'b0};
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            result    <= '0;
            eq        <= 1'b0;
            count     <= '0;
            work      <= '0;
            operand   <= '0;
            want_hi   <= 1'b0;
`ifdef ALU_MULDIV_DIV_EN
            is_div    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        eq       <= (op1 == op2);
                        operand  <= op2;
                        want_hi  <= ctrl[0];
                        in_ready <= 1'b0;
`ifdef ALU_MULDIV_DIV_EN
                        is_div   <= ctrl[2];
`endif
                        if (is_iter) begin
                            work  <= {{WIDTH{1'b0}}, op1};
                            count <= CW'(WIDTH);
                            state <= BUSY;
                            busy  <= 1'b1;
                        end else begin
                            result    <= alu_res;
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    work  <= work_next;
                    count <= count - CW'(1);
                    if (count == CW'(1)) begin
                        result    <= want_hi ? work_next[2*WIDTH-1:WIDTH] : work_next[WIDTH-1:0];
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: directed scoreboard bench for alu_muldiv at WIDTH=32.
// Divider expectations follow ALU_MULDIV_DIV_EN the same way the design does.
`timescale 1ns/1ps
module tb_alu_muldiv;
    localparam int WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic [3:0]       ctrl;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             eq;
    logic             busy;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             eq;
        string            name;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    alu_muldiv #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op1(op1), .op2(op2), .ctrl(ctrl), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .eq(eq), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Monitor: every retired result is matched against the oldest expectation
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_result", 64'(result), 64'hdead);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput({e.name, "_result"}, 64'(result), 64'(e.res));
                checkOutput({e.name, "_eq"}, 64'(eq), 64'(e.eq));
            end
        end
    end

    // Called #1 after a rising edge; returns #1 after the edge where the block is back in IDLE
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic [3:0] c, input logic [WIDTH-1:0] exp_res,
                                 input int exp_lat, input string name);
        int lat;
        int busy_cnt;
        int guard;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1; guard++;
        end
        checkOutput({name, "_ready_wait"}, 64'(in_ready), 64'd1);
        op1 = a; op2 = b; ctrl = c; in_valid = 1'b1;
        @(posedge clk);
        exp_q.push_back('{exp_res, (a == b), name});
        #1;
        in_valid = 1'b0;
        op1 = $urandom; op2 = $urandom; ctrl = 4'($urandom);
        lat = 1;
        busy_cnt = 0;
        while (!out_valid && lat < 200) begin
            if (busy) busy_cnt++;
            @(posedge clk); #1;
            lat++;
        end
        checkOutput({name, "_latency"}, 64'(lat), 64'(exp_lat));
        checkOutput({name, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_lat - 1));
        checkOutput({name, "_in_ready_done"}, 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        checkOutput({name, "_out_valid_after"}, 64'(out_valid), 64'd0);
        checkOutput({name, "_in_ready_after"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int div_lat;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op1 = '0; op2 = '0; ctrl = '0;
        #12;
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_result", 64'(result), 64'd0);
        checkOutput("reset_eq", 64'(eq), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        applyStimulus(32'd7, 32'd5, 4'b0001, 32'd2, 1, "sub_7_5");
        applyStimulus(32'hFFFFFFFF, 32'd2, 4'b0000, 32'd1, 1, "add_wrap");
        applyStimulus(32'd0, 32'd1, 4'b0001, 32'hFFFFFFFF, 1, "sub_wrap");
        applyStimulus(32'd3, 32'd5, 4'b0101, 32'd1, 1, "slt_true");
        applyStimulus(32'd5, 32'd3, 4'b0101, 32'd0, 1, "slt_false");
        applyStimulus(32'd9, 32'd9, 4'b0101, 32'd0, 1, "slt_equal");
        applyStimulus(32'hF0, 32'h0F, 4'b0011, 32'hFF, 1, "or");
        applyStimulus(32'hFF0, 32'h0F0, 4'b0010, 32'h0F0, 1, "and");
        applyStimulus(32'd11, 32'd22, 4'b0111, 32'd0, 1, "undef_op");
        applyStimulus(32'hFFFFFFFF, 32'd2, 4'b1001, 32'd1, WIDTH + 1, "mulhu");
        applyStimulus(32'hFFFFFFFF, 32'd2, 4'b1000, 32'hFFFFFFFE, WIDTH + 1, "mul");
        applyStimulus(32'd12345, 32'd678, 4'b1000, 32'h007FB6F6, WIDTH + 1, "mul_small");
        applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 4'b1001, 32'hFFFFFFFE, WIDTH + 1, "mulhu_max");

`ifdef ALU_MULDIV_DIV_EN
        div_lat = WIDTH + 1;
        applyStimulus(32'd100, 32'd7, 4'b1100, 32'd14, div_lat, "divu");
        applyStimulus(32'd100, 32'd7, 4'b1101, 32'd2, div_lat, "remu");
        applyStimulus(32'd100, 32'd0, 4'b1100, 32'hFFFFFFFF, div_lat, "divu_zero");
        applyStimulus(32'd100, 32'd0, 4'b1101, 32'd100, div_lat, "remu_zero");
`else
        div_lat = 1;
        applyStimulus(32'd100, 32'd7, 4'b1100, 32'd0, div_lat, "divu_absent");
        applyStimulus(32'd100, 32'd7, 4'b1101, 32'd0, div_lat, "remu_absent");
`endif

        // Stall in DONE: outputs hold and a new request is ignored
        out_ready = 1'b0;
        op1 = 32'd10; op2 = 32'd10; ctrl = 4'b0000; in_valid = 1'b1;
        @(posedge clk);
        exp_q.push_back('{32'd20, 1'b1, "stall_add"});
        #1;
        op1 = 32'd1; op2 = 32'd2; ctrl = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            checkOutput("stall_out_valid", 64'(out_valid), 64'd1);
            checkOutput("stall_result", 64'(result), 64'd20);
            checkOutput("stall_eq", 64'(eq), 64'd1);
            checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("stall_release_out_valid", 64'(out_valid), 64'd0);
        checkOutput("stall_release_in_ready", 64'(in_ready), 64'd1);

        // Reset during a multiply: nothing delivered, next op is clean
        op1 = 32'd5; op2 = 32'd5; ctrl = 4'b1000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
        end
        checkOutput("abort_busy_before", 64'(busy), 64'd1);
        checkOutput("abort_eq_before", 64'(eq), 64'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_in_ready", 64'(in_ready), 64'd1);
        checkOutput("abort_out_valid", 64'(out_valid), 64'd0);
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_result", 64'(result), 64'd0);
        checkOutput("abort_eq", 64'(eq), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        applyStimulus(32'd3, 32'd4, 4'b0000, 32'd7, 1, "add_after_reset");

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
